// File: rtl/mux_pkg.sv
// mux_pkg: constants and helpers shared by the round-robin N-to-1 mux.
//   MODE_RR / MODE_FIXED : encodings for the mode_i arbitration-mode input.
//   sel_width(ch)        : width of a channel index; 1 bit for a single channel.
package mux_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    function automatic int sel_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// rr_grant: combinational arbiter for mux_rr_nto1.
//   req_i     : one request bit per channel.
//   ptr_i     : round-robin start index; only used when mode_i selects round-robin.
//   mode_i    : MODE_RR scans ptr_i, ptr_i+1, ... wrapping; MODE_FIXED picks the lowest index.
//   gnt_idx_o : index of the granted channel; 0 when nothing is requested.
//   gnt_any_o : at least one request is present.
module rr_grant
    import mux_pkg::*;
#(
    parameter int CH    = 4,
    parameter int SEL_W = sel_width(CH)
) (
    input  logic [CH-1:0]    req_i,
    input  logic [SEL_W-1:0] ptr_i,
    input  logic             mode_i,
    output logic [SEL_W-1:0] gnt_idx_o,
    output logic             gnt_any_o
);

    int               pos;
    logic [SEL_W-1:0] idx;

    always_comb begin
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        pos       = 0;
        idx       = '0;
        // Walk from the farthest scan position back to the nearest, so the last
        // hit written is the first one in scan order.
        for (int i = CH - 1; i >= 0; i--) begin
            if (mode_i == MODE_FIXED) begin
                pos = i;
            end else begin
                pos = (int'(ptr_i) + i) % CH;
            end
            idx = SEL_W'(pos);
            if (req_i[idx]) begin
                gnt_idx_o = idx;
                gnt_any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_nto1.sv
// mux_rr_nto1: arbitrated CH-to-1 mux with one registered output stage.
//   clk_i   : clock, all state updates on the rising edge.
//   rst_i   : synchronous active-high reset; clears the output stage and the pointer.
//   mode_i  : 0 = round-robin, 1 = fixed priority (lowest index wins).
//   data_i  : CH packed lanes, lane k at [k*SIZE +: SIZE].
//   valid_i : per-channel word present.
//   ready_o : per-channel accept strobe; at most one bit set.
//   data_o  : registered selected word.
//   sel_o   : channel index that supplied data_o.
//   valid_o : data_o/sel_o hold a word.
//   ready_i : downstream accepts data_o this cycle.
module mux_rr_nto1
    import mux_pkg::*;
#(
    parameter  int SIZE  = 32,
    parameter  int CH    = 4,
    localparam int SEL_W = sel_width(CH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               mode_i,
    input  logic [CH*SIZE-1:0] data_i,
    input  logic [CH-1:0]      valid_i,
    output logic [CH-1:0]      ready_o,
    output logic [SIZE-1:0]    data_o,
    output logic [SEL_W-1:0]   sel_o,
    output logic               valid_o,
    input  logic               ready_i
);

    logic [SIZE-1:0]  data_q, data_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_any;
    logic             can_load;
    logic             in_xfer;
    logic [SIZE-1:0]  gnt_data;
    logic [SEL_W-1:0] ptr_next;

    rr_grant #(
        .CH    (CH),
        .SEL_W (SEL_W)
    ) u_grant (
        .req_i     (valid_i),
        .ptr_i     (ptr_q),
        .mode_i    (mode_i),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    // The stage can take a new word when empty or when its word leaves this cycle.
    assign can_load = !valid_q || ready_i;
    assign in_xfer  = can_load && gnt_any;

    // Only the granted lane is ever observed, so unselected lanes cannot leak in.
    always_comb begin
        gnt_data = '0;
        ready_o  = '0;
        for (int k = 0; k < CH; k++) begin
            if (gnt_idx == SEL_W'(k)) begin
                gnt_data   = data_i[k*SIZE +: SIZE];
                ready_o[k] = in_xfer;
            end
        end
    end

    assign ptr_next = (gnt_idx == SEL_W'(CH - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (in_xfer) begin
            data_d  = gnt_data;
            sel_d   = gnt_idx;
            valid_d = 1'b1;
            if (mode_i == MODE_RR) begin
                ptr_d = ptr_next;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign data_o  = data_q;
    assign sel_o   = sel_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_mux_rr_nto1.sv
// tb_mux_rr_nto1: scoreboard bench for mux_rr_nto1 (CH=4, SIZE=32).
// The stimulus process drives one cycle at a time, predicts grants from the
// arbitration rules and queues each accepted word; a monitor pops and compares
// on every output transfer.
module tb_mux_rr_nto1;

    localparam int CH    = 4;
    localparam int SIZE  = 32;
    localparam int SEL_W = 2;

    logic               clk = 1'b0;
    logic               rst_i;
    logic               mode_i;
    logic [CH*SIZE-1:0] data_i;
    logic [CH-1:0]      valid_i;
    logic [CH-1:0]      ready_o;
    logic [SIZE-1:0]    data_o;
    logic [SEL_W-1:0]   sel_o;
    logic               valid_o;
    logic               ready_i;

    mux_rr_nto1 #(
        .SIZE (SIZE),
        .CH   (CH)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .mode_i  (mode_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .sel_o   (sel_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [SIZE-1:0]  data;
    } word_t;

    word_t           sb_q[$];
    logic [SIZE-1:0] chan_data[CH];
    int              n_checks = 0;
    int              n_errors = 0;
    int              m_ptr    = 0;
    bit              m_full   = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Channel that the arbitration rules select, or -1 when none requests.
    function automatic int exp_grant(input logic [CH-1:0] v, input bit fixed, input int ptr);
        for (int i = 0; i < CH; i++) begin
            int k;
            k = fixed ? i : (ptr + i) % CH;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // Drive one cycle, sample just before the next rising edge, then update the model.
    task automatic step(input bit rst, input bit mode, input logic [CH-1:0] v, input bit rdy);
        int            g;
        bit            can_load;
        logic [CH-1:0] exp_rdy;
        word_t         w;
        @(posedge clk);
        #1;
        rst_i   = rst;
        mode_i  = mode;
        valid_i = v;
        ready_i = rdy;
        for (int k = 0; k < CH; k++) data_i[k*SIZE +: SIZE] = chan_data[k];
        #7;
        g        = exp_grant(v, mode, m_ptr);
        can_load = !m_full || rdy;
        exp_rdy  = '0;
        if (can_load && g >= 0) exp_rdy[g] = 1'b1;
        check("ready_o", ready_o, exp_rdy);
        check("valid_o", valid_o, m_full);
        if (rst) begin
            m_full = 1'b0;
            m_ptr  = 0;
            sb_q.delete();
        end else if (can_load && g >= 0) begin
            w.sel  = SEL_W'(g);
            w.data = chan_data[g];
            sb_q.push_back(w);
            m_full = 1'b1;
            if (!mode) m_ptr = (g + 1) % CH;
        end else if (m_full && rdy) begin
            m_full = 1'b0;
        end
    endtask

    // Monitor: compares every delivered word and checks the output holds during stalls.
    initial begin : monitor
        bit               prev_stall;
        bit               prev_rst;
        logic [SIZE-1:0]  prev_data;
        logic [SEL_W-1:0] prev_sel;
        word_t            w;
        prev_stall = 1'b0;
        prev_rst   = 1'b1;
        prev_data  = '0;
        prev_sel   = '0;
        forever begin
            @(posedge clk);
            #8;
            if (prev_stall && !prev_rst) begin
                check("stall_data", data_o, prev_data);
                check("stall_sel", sel_o, prev_sel);
            end
            if (!rst_i && valid_o && ready_i) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got sel %0d data %0h, required no word",
                             sel_o, data_o);
                end else begin
                    w = sb_q.pop_front();
                    check("out_data", data_o, w.data);
                    check("out_sel", sel_o, w.sel);
                end
            end
            prev_stall = valid_o && !ready_i;
            prev_rst   = rst_i;
            prev_data  = data_o;
            prev_sel   = sel_o;
        end
    end

    initial begin : stimulus
        logic [CH-1:0] one;
        bit            mode_r;
        one     = 1;
        rst_i   = 1'b1;
        mode_i  = 1'b0;
        valid_i = '0;
        ready_i = 1'b0;
        data_i  = '0;
        for (int k = 0; k < CH; k++) chan_data[k] = '0;

        // Reset state.
        step(1, 0, 4'b0000, 0);
        step(0, 0, 4'b0000, 1);
        check("reset_valid", valid_o, 1'b0);
        check("reset_data", data_o, 32'h0);
        check("reset_sel", sel_o, 2'd0);

        // Reset while a word is stalled: the word is discarded.
        chan_data[2] = 32'hDEAD_BEEF;
        step(0, 0, 4'b0100, 0);
        step(0, 0, 4'b0000, 0);
        check("stall_held", data_o, 32'hDEAD_BEEF);
        step(1, 0, 4'b0000, 0);
        step(0, 0, 4'b0000, 0);
        check("rst_mid_valid", valid_o, 1'b0);
        check("rst_mid_data", data_o, 32'h0);
        check("rst_mid_sel", sel_o, 2'd0);
        check("rst_mid_ready", ready_o, 4'b0000);

        // Round-robin fairness with all channels requesting.
        for (int k = 0; k < CH; k++) chan_data[k] = 32'h100 + k;
        for (int n = 0; n < 6; n++) begin
            step(0, 0, 4'b1111, 1);
            check("rr_ready", ready_o, one << (n % 4));
            if (n > 0) check("rr_data", data_o, 32'h100 + ((n - 1) % 4));
        end

        // Fixed priority: ch1 always beats ch3.
        for (int n = 0; n < 4; n++) begin
            step(0, 1, 4'b1010, 1);
            check("fixed_ready", ready_o, 4'b0010);
            if (n > 0) check("fixed_sel", sel_o, 2'd1);
        end

        // Backpressure, then drain and reload in the same cycle.
        chan_data[0] = 32'hA0A0_0001;
        step(0, 0, 4'b0001, 1);
        chan_data[0] = 32'hB0B0_0002;
        for (int n = 0; n < 3; n++) begin
            step(0, 0, 4'b0001, 0);
            check("bp_ready", ready_o, 4'b0000);
            check("bp_data", data_o, 32'hA0A0_0001);
        end
        step(0, 0, 4'b0001, 1);
        check("bp_reload", ready_o, 4'b0001);
        step(0, 0, 4'b0000, 1);
        check("bp_new_data", data_o, 32'hB0B0_0002);

        // Wrap: ch2 transfer leaves ptr at 3, lone ch0 wins, ptr moves to 1.
        step(0, 0, 4'b0100, 1);
        check("wrap_ch2", ready_o, 4'b0100);
        step(0, 0, 4'b0001, 1);
        check("wrap_ch0", ready_o, 4'b0001);
        step(0, 0, 4'b0011, 1);
        check("wrap_ptr1", ready_o, 4'b0010);

        // Mode switch with ptr at 2 (left by the ch1 transfer above).
        step(0, 1, 4'b0101, 1);
        check("mode_fixed", ready_o, 4'b0001);
        step(0, 0, 4'b0101, 1);
        check("mode_rr", ready_o, 4'b0100);

        // Randomized traffic with occasional reset and mode flips.
        mode_r = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < CH; k++) chan_data[k] = $urandom;
            if ($urandom_range(0, 19) == 0) mode_r = ~mode_r;
            step(($urandom_range(0, 99) == 0), mode_r, CH'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Drain and confirm every accepted word was delivered.
        for (int n = 0; n < 4; n++) step(0, 0, 4'b0000, 1);
        #1;
        check("drain_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_nto1.md
Name: mux_rr_nto1

Overview:
- Parametrised successor to the 2-to-1 datapath mux: selects one of CH input channels of SIZE bits, drives a single registered output.
- Selection is by arbitration over a valid/ready handshake, not a static select line.
- Intended for shared datapath resources in the pipelined CPU, e.g. a shared writeback or memory port fed by several pipeline sources.
- Two arbitration modes: round-robin (fair) and fixed priority (lowest index wins). One output register stage.

Parameters:
- SIZE, 32, data width per channel in bits.
- CH, 4, number of input channels; legal range 1..16.
- SEL_W, (CH>1 ? $clog2(CH) : 1), width of the channel index; derived, not overridden.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- mode_i  input  1  0 = round-robin, 1 = fixed priority.
- data_i  input  CH*SIZE  channel k occupies bits [k*SIZE +: SIZE].
- valid_i  input  CH  channel k presents a word.
- ready_o  output  CH  channel k's word is accepted this cycle.
- data_o  output  SIZE  registered selected word.
- sel_o  output  SEL_W  index of the channel that supplied data_o.
- valid_o  output  1  data_o/sel_o hold a word.
- ready_i  input  1  downstream accepts data_o this cycle.

Behaviour:
- Reset (rst_i=1 at a clock edge): valid_o=0, data_o=0, sel_o=0, round-robin pointer ptr=0. Reset wins over every other event in that cycle. A word held mid-transfer is discarded, not delivered.
- Transfers:
  - Input transfer on channel k when valid_i[k] & ready_o[k].
  - Output transfer when valid_o & ready_i.
- can_load = !valid_o | ready_i. Full throughput: one word in and one out in the same cycle.
- Grant (combinational from valid_i, ptr, mode_i):
  - mode_i=0: first asserted valid_i scanning ptr, ptr+1, ..., wrapping mod CH.
  - mode_i=1: lowest asserted index.
- ready_o[k] = can_load & (grant == k). At most one bit of ready_o is set. ready_o is all-zero when no valid_i is set or can_load=0.
- ready_o must not depend combinationally on ready_o from other instances. It may depend on ready_i.
- Load on input transfer from channel g: data_o <= data_i[g], sel_o <= g, valid_o <= 1.
- Latency: 1 cycle from input transfer to valid_o.
- On output transfer with no input transfer: valid_o <= 0. data_o and sel_o keep their last values.
- Stall (valid_o & !ready_i): data_o, sel_o and valid_o are held stable. No ready_o is asserted.
- Pointer:
  - In mode 0, after an input transfer from g: ptr <= (g+1) mod CH. Wrap: g=CH-1 gives ptr=0.
  - In mode 1, ptr is unchanged.
  - mode_i changes take effect on the next grant evaluation. No word is lost or duplicated.
- Inputs may drop valid_i without a transfer; the arbiter re-evaluates every cycle.
- CH=1: grant is always 0, sel_o is constantly 0, and the block degenerates to a one-stage register slice.
- No X propagation: unselected data_i lanes never affect outputs.

Decomposition:
- Shared package mux_pkg:
  - MODE_RR=1'b0 and MODE_FIXED=1'b1 constants.
  - sel_width(ch) function used for SEL_W.
- One sub-module: rr_grant. Purely combinational: inputs req[CH], ptr[SEL_W], mode. Outputs gnt_idx[SEL_W] and gnt_any.
- The register stage and pointer stay in mux_rr_nto1.

Test Plan:
- Reset mid-stall: load ch2=32'hDEAD_BEEF, hold ready_i=0, pulse rst_i. Required next cycle: valid_o=0, data_o=0, sel_o=0, ready_o=4'b0000 for one cycle after rst_i drops only if valid_i=0.
- Round-robin fairness: mode 0, valid_i=4'b1111 constant, ready_i=1, channel k data = k+32'h100. Required sel_o sequence 0,1,2,3,0,1 with data_o=32'h100..103 repeating, one word per cycle.
- Fixed priority starvation: mode 1, valid_i=4'b1010, ready_i=1. Required: every transfer from ch1 (sel_o=1), ready_o=4'b0010 each cycle, ch3 never granted.
- Backpressure: mode 0, valid_i=4'b0001, ready_i=0 for 3 cycles after first load. Required: ready_o=0 during stall, data_o stable. Then ready_i=1 gives one output transfer and an immediate reload the same cycle.
- Wrap and sparse request: mode 0, ptr driven to 3 via a ch2 transfer, then valid_i=4'b0001. Required: grant ch0 (wrap), ptr becomes 1.
- Mode switch: mode 0 with ptr=2, valid_i=4'b0101, switch mode_i to 1 the same cycle. Required: grant ch0. Switch back to 0: next grant ch2.
